// File: rtl/riscv_pkg.sv
// ----------------------------------------------------------------------------
// riscv_pkg
//   Shared RV32I encodings used by the load/store path.
//   Holds the funct3 values for loads and stores, the fixed data width, and
//   two helpers that tell whether a funct3 is a legal load or store size.
// ----------------------------------------------------------------------------
package riscv_pkg;

  localparam int XLEN = 32;

  // Load funct3 encodings (instr[14:12])
  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  // Store funct3 encodings (instr[14:12])
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  // Loads have five legal sizes; 011, 110 and 111 are reserved.
  function automatic logic isLegalLoadF3(input logic [2:0] f3);
    return (f3 == F3_LB) || (f3 == F3_LH) || (f3 == F3_LW) ||
           (f3 == F3_LBU) || (f3 == F3_LHU);
  endfunction

  // Stores only have byte, half and word.
  function automatic logic isLegalStoreF3(input logic [2:0] f3);
    return (f3 == F3_SB) || (f3 == F3_SH) || (f3 == F3_SW);
  endfunction

endpackage

// File: rtl/lsu_align.sv
// ----------------------------------------------------------------------------
// lsu_align
//   Purely combinational RV32I load/store alignment for one 32-bit word.
//   Ports:
//     i_funct3      access size/sign (instr[14:12])
//     i_addrLo      byte offset within the word (addr[1:0])
//     i_rawWord     word currently stored at the addressed location
//     i_wrData      store data from rs2
//     o_byteEn      per-lane write enables for stores
//     o_storeData   store data replicated into the addressed lane(s)
//     o_loadData    selected lane(s), sign- or zero-extended
//     o_ldMisalign  load is not naturally aligned for its size
//     o_ldIllegal   load funct3 is reserved
//     o_stMisalign  store is not naturally aligned for its size
//     o_stIllegal   store funct3 is reserved
// ----------------------------------------------------------------------------
module lsu_align
  import riscv_pkg::*;
(
  input  logic [2:0]      i_funct3,
  input  logic [1:0]      i_addrLo,
  input  logic [XLEN-1:0] i_rawWord,
  input  logic [XLEN-1:0] i_wrData,
  output logic [3:0]      o_byteEn,
  output logic [XLEN-1:0] o_storeData,
  output logic [XLEN-1:0] o_loadData,
  output logic            o_ldMisalign,
  output logic            o_ldIllegal,
  output logic            o_stMisalign,
  output logic            o_stIllegal
);

  logic [7:0]  w_loadByte;
  logic [15:0] w_loadHalf;

  // Lane extraction for loads: the byte lane follows addr[1:0], the half
  // lane follows addr[1] (addr[0] is guaranteed 0 for legal halves).
  always_comb begin
    w_loadByte = 8'h00;
    case (i_addrLo)
      2'd0: w_loadByte = i_rawWord[7:0];
      2'd1: w_loadByte = i_rawWord[15:8];
      2'd2: w_loadByte = i_rawWord[23:16];
      2'd3: w_loadByte = i_rawWord[31:24];
      default: w_loadByte = 8'h00;
    endcase
    w_loadHalf = i_addrLo[1] ? i_rawWord[31:16] : i_rawWord[15:0];
  end

  // Extend the selected lane according to the load size/sign.
  always_comb begin
    o_loadData = '0;
    case (i_funct3)
      F3_LB:   o_loadData = {{24{w_loadByte[7]}}, w_loadByte};
      F3_LH:   o_loadData = {{16{w_loadHalf[15]}}, w_loadHalf};
      F3_LW:   o_loadData = i_rawWord;
      F3_LBU:  o_loadData = {24'h000000, w_loadByte};
      F3_LHU:  o_loadData = {16'h0000, w_loadHalf};
      default: o_loadData = '0;
    endcase
  end

  // Store data is replicated across all lanes so the byte enables alone
  // decide which lane lands in memory.
  always_comb begin
    o_byteEn    = 4'b0000;
    o_storeData = i_wrData;
    case (i_funct3)
      F3_SB: begin
        o_byteEn    = 4'b0001 << i_addrLo;
        o_storeData = {4{i_wrData[7:0]}};
      end
      F3_SH: begin
        o_byteEn    = i_addrLo[1] ? 4'b1100 : 4'b0011;
        o_storeData = {2{i_wrData[15:0]}};
      end
      F3_SW: begin
        o_byteEn    = 4'b1111;
        o_storeData = i_wrData;
      end
      default: begin
        o_byteEn    = 4'b0000;
        o_storeData = i_wrData;
      end
    endcase
  end

  // Alignment and encoding checks, kept separate for loads and stores
  // because the legal funct3 sets differ.
  always_comb begin
    o_ldIllegal  = ~isLegalLoadF3(i_funct3);
    o_stIllegal  = ~isLegalStoreF3(i_funct3);
    o_ldMisalign = 1'b0;
    o_stMisalign = 1'b0;
    if ((i_funct3 == F3_LH) || (i_funct3 == F3_LHU))
      o_ldMisalign = i_addrLo[0];
    else if (i_funct3 == F3_LW)
      o_ldMisalign = (i_addrLo != 2'b00);
    if (i_funct3 == F3_SH)
      o_stMisalign = i_addrLo[0];
    else if (i_funct3 == F3_SW)
      o_stMisalign = (i_addrLo != 2'b00);
  end

endmodule

// File: rtl/data_memory.sv
// ----------------------------------------------------------------------------
// data_memory
//   Byte-addressable RV32I data memory for the MEM stage of the single-cycle
//   core. Combinational read, synchronous byte-lane write, and a debug
//   register that latches the address of the first illegal access.
//   Ports:
//     clk           rising-edge clock
//     reset         synchronous active-high reset (array is not cleared)
//     mem_read      load in the current instruction
//     mem_write     store in the current instruction
//     funct3        access size and sign
//     addr          byte address from the ALU
//     wr_data       store data (rs2)
//     rd_data       extended, right-justified load result
//     access_err    current access is misaligned, out of range or reserved
//     fault_sticky  an illegal access has happened since reset/clear
//     fault_addr    address of that first illegal access
//     fault_clr     clears the fault register at the next edge
// ----------------------------------------------------------------------------
module data_memory
  import riscv_pkg::*;
#(
  parameter int DEPTH      = 256,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  mem_read,
  input  logic                  mem_write,
  input  logic [2:0]            funct3,
  input  logic [31:0]           addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  access_err,
  output logic                  fault_sticky,
  output logic [31:0]           fault_addr,
  input  logic                  fault_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [DATA_WIDTH-1:0] r_mem [DEPTH];
  logic                  r_faultSticky;
  logic [31:0]           r_faultAddr;

  logic [AW-1:0]         w_wordIdx;
  logic                  w_outOfRange;
  logic [DATA_WIDTH-1:0] w_rawWord;
  logic [3:0]            w_byteEn;
  logic [DATA_WIDTH-1:0] w_storeData;
  logic [DATA_WIDTH-1:0] w_loadData;
  logic                  w_ldMisalign;
  logic                  w_ldIllegal;
  logic                  w_stMisalign;
  logic                  w_stIllegal;
  logic                  w_accessErr;
  logic                  w_doWrite;

  assign w_wordIdx = addr[AW+1:2];
  // Any set bit above the array's byte span means addr >= DEPTH*4.
  assign w_outOfRange = (addr[31:AW+2] != '0);
  assign w_rawWord = r_mem[w_wordIdx];

  lsu_align u_lsuAlign (
    .i_funct3     (funct3),
    .i_addrLo     (addr[1:0]),
    .i_rawWord    (w_rawWord),
    .i_wrData     (wr_data),
    .o_byteEn     (w_byteEn),
    .o_storeData  (w_storeData),
    .o_loadData   (w_loadData),
    .o_ldMisalign (w_ldMisalign),
    .o_ldIllegal  (w_ldIllegal),
    .o_stMisalign (w_stMisalign),
    .o_stIllegal  (w_stIllegal)
  );

  // Each side is judged with its own funct3 rules; reset masks the flag so
  // nothing is reported or captured while the core is held.
  always_comb begin
    w_accessErr = 1'b0;
    if (!reset) begin
      w_accessErr = (mem_read  & (w_ldMisalign | w_ldIllegal | w_outOfRange)) |
                    (mem_write & (w_stMisalign | w_stIllegal | w_outOfRange));
    end
  end

  assign access_err = w_accessErr;
  assign w_doWrite  = mem_write & ~reset & ~w_accessErr;
  assign rd_data    = (mem_read & ~reset & ~w_accessErr) ? w_loadData : '0;

  // Array write; rd_data above still shows the pre-edge word when a read
  // and a write to the same address share a cycle.
  always_ff @(posedge clk) begin
    if (w_doWrite) begin
      for (int i = 0; i < 4; i++) begin
        if (w_byteEn[i])
          r_mem[w_wordIdx][8*i +: 8] <= w_storeData[8*i +: 8];
      end
    end
  end

  // First-fault capture: a new fault is taken when nothing is held or when
  // a clear arrives in the same cycle (set beats clear).
  always_ff @(posedge clk) begin
    if (reset) begin
      r_faultSticky <= 1'b0;
      r_faultAddr   <= 32'h0;
    end else if (w_accessErr && (!r_faultSticky || fault_clr)) begin
      r_faultSticky <= 1'b1;
      r_faultAddr   <= addr;
    end else if (fault_clr && !w_accessErr) begin
      r_faultSticky <= 1'b0;
      r_faultAddr   <= 32'h0;
    end
  end

  assign fault_sticky = r_faultSticky;
  assign fault_addr   = r_faultAddr;

endmodule

// File: tb/tb_data_memory.sv
// ----------------------------------------------------------------------------
// tb_data_memory
//   Directed self-checking bench for data_memory with hand-computed
//   expected values for loads, stores, alignment faults and the fault
//   register.
// ----------------------------------------------------------------------------
module tb_data_memory;

  logic        clk;
  logic        reset;
  logic        memRead;
  logic        memWrite;
  logic [2:0]  funct3;
  logic [31:0] addr;
  logic [31:0] wrData;
  logic [31:0] rdData;
  logic        accessErr;
  logic        faultSticky;
  logic [31:0] faultAddr;
  logic        faultClr;

  int checkCount = 0;
  int errorCount = 0;

  data_memory #(.DEPTH(256), .DATA_WIDTH(32)) dut (
    .clk          (clk),
    .reset        (reset),
    .mem_read     (memRead),
    .mem_write    (memWrite),
    .funct3       (funct3),
    .addr         (addr),
    .wr_data      (wrData),
    .rd_data      (rdData),
    .access_err   (accessErr),
    .fault_sticky (faultSticky),
    .fault_addr   (faultAddr),
    .fault_clr    (faultClr)
  );

  // 10 ns clock
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Compare one observed value with its expected value and log mismatches.
  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", tag, observed, expected);
    end
  endtask

  // Drive one access (called just after a rising edge) and let it settle.
  task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                               input logic [31:0] a, input logic [31:0] wd,
                               input logic clr);
    memRead  = rd;
    memWrite = wr;
    funct3   = f3;
    addr     = a;
    wrData   = wd;
    faultClr = clr;
    #2;
  endtask

  // Advance through one rising edge and sample shortly after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0002, 32'h0, 1'b0);
    checkOutput("rst_access_err", {31'b0, accessErr}, 32'h0);
    checkOutput("rst_rd_data", rdData, 32'h0);
    tick();
    tick();
    checkOutput("rst_sticky", {31'b0, faultSticky}, 32'h0);
    checkOutput("rst_fault_addr", faultAddr, 32'h0);
    reset = 1'b0;

    // SW DEADBEEF @0x10 and the five load flavours back
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 1'b0);
    checkOutput("sw_err", {31'b0, accessErr}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checkOutput("lw_10", rdData, 32'hDEADBEEF);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h13, 32'h0, 1'b0);
    checkOutput("lb_13", rdData, 32'hFFFFFFDE);
    applyStimulus(1'b1, 1'b0, 3'b100, 32'h11, 32'h0, 1'b0);
    checkOutput("lbu_11", rdData, 32'h000000BE);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h12, 32'h0, 1'b0);
    checkOutput("lh_12", rdData, 32'hFFFFDEAD);
    applyStimulus(1'b1, 1'b0, 3'b101, 32'h10, 32'h0, 1'b0);
    checkOutput("lhu_10", rdData, 32'h0000BEEF);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checkOutput("no_read_zero", rdData, 32'h0);

    // SB / SH only touch their lanes
    applyStimulus(1'b0, 1'b1, 3'b000, 32'h11, 32'hAAAAAA55, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checkOutput("lw_after_sb", rdData, 32'hDEAD55EF);
    applyStimulus(1'b1, 1'b0, 3'b000, 32'h11, 32'h0, 1'b0);
    checkOutput("lb_pos_11", rdData, 32'h00000055);
    applyStimulus(1'b0, 1'b1, 3'b001, 32'h12, 32'hFFFF1234, 1'b0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checkOutput("lw_after_sh", rdData, 32'h123455EF);
    checkOutput("sticky_clean", {31'b0, faultSticky}, 32'h0);

    // Misaligned SW: flagged, not written, first fault kept
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h12, 32'h0BADBAD0, 1'b0);
    checkOutput("sw_mis_err", {31'b0, accessErr}, 32'h1);
    tick();
    checkOutput("sw_mis_sticky", {31'b0, faultSticky}, 32'h1);
    checkOutput("sw_mis_addr", faultAddr, 32'h12);
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b0);
    checkOutput("lw_unchanged", rdData, 32'h123455EF);
    applyStimulus(1'b1, 1'b0, 3'b001, 32'h21, 32'h0, 1'b0);
    checkOutput("lh_mis_err", {31'b0, accessErr}, 32'h1);
    checkOutput("lh_mis_rd", rdData, 32'h0);
    tick();
    checkOutput("first_fault_kept", faultAddr, 32'h12);

    // Clear with a legal access
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h10, 32'h0, 1'b1);
    tick();
    checkOutput("clr_sticky", {31'b0, faultSticky}, 32'h0);
    checkOutput("clr_addr", faultAddr, 32'h0);

    // Out of range: first address past the array
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h400, 32'h0, 1'b0);
    checkOutput("oor_err", {31'b0, accessErr}, 32'h1);
    checkOutput("oor_rd", rdData, 32'h0);
    tick();
    checkOutput("oor_sticky", {31'b0, faultSticky}, 32'h1);
    checkOutput("oor_addr", faultAddr, 32'h400);
    applyStimulus(1'b0, 1'b0, 3'b010, 32'h0, 32'h0, 1'b1);
    tick();
    checkOutput("clr2_sticky", {31'b0, faultSticky}, 32'h0);

    // Reserved load funct3 together with clear: set wins
    applyStimulus(1'b1, 1'b0, 3'b011, 32'h30, 32'h0, 1'b1);
    checkOutput("ill_ld_err", {31'b0, accessErr}, 32'h1);
    tick();
    checkOutput("ill_ld_sticky", {31'b0, faultSticky}, 32'h1);
    checkOutput("ill_ld_addr", faultAddr, 32'h30);
    // Reserved store funct3 with clear while already faulted: re-captured
    applyStimulus(1'b0, 1'b1, 3'b011, 32'h44, 32'h0, 1'b1);
    tick();
    checkOutput("ill_st_recapture", faultAddr, 32'h44);

    // Last word of the array is still in range
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h3FC, 32'hA5A5A5A5, 1'b0);
    checkOutput("top_word_err", {31'b0, accessErr}, 32'h0);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h3FC, 32'h0, 1'b0);
    checkOutput("top_word_rd", rdData, 32'hA5A5A5A5);

    // Reset blocks writes and clears the fault register
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'h11223344, 1'b0);
    tick();
    reset = 1'b1;
    applyStimulus(1'b0, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
    tick();
    checkOutput("rst2_sticky", {31'b0, faultSticky}, 32'h0);
    checkOutput("rst2_addr", faultAddr, 32'h0);
    reset = 1'b0;
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    checkOutput("rst_no_write", rdData, 32'h11223344);

    // Read and write together: old data now, new data after the edge
    applyStimulus(1'b1, 1'b1, 3'b010, 32'h20, 32'hCAFEF00D, 1'b0);
    checkOutput("rw_old", rdData, 32'h11223344);
    tick();
    applyStimulus(1'b1, 1'b0, 3'b010, 32'h20, 32'h0, 1'b0);
    checkOutput("rw_new", rdData, 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule
